// File: rtl/ext_op_sched.sv
// Shared controller for the extended integer ops (inc/dec/slt/sgt/lui/ham).
// Two requesters are served round-robin; results return on one valid/ready channel.
module ext_op_sched #(
  parameter int unsigned HAM_BITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [5:0]  req_op,
  input  logic [63:0] req_a,
  input  logic [63:0] req_b,
  input  logic [31:0] req_imm,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_data,
  output logic        rsp_flag,
  output logic        rsp_err,
  output logic        busy
);

  localparam int unsigned HAM_CYC = 32 / HAM_BITS;
  localparam int unsigned CNT_W   = 6;
  localparam int unsigned PC_W    = 4;

  localparam logic [2:0] OP_INC = 3'd0;
  localparam logic [2:0] OP_DEC = 3'd1;
  localparam logic [2:0] OP_SLT = 3'd2;
  localparam logic [2:0] OP_SGT = 3'd3;
  localparam logic [2:0] OP_LUI = 3'd4;
  localparam logic [2:0] OP_HAM = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_HAM, S_RESP} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_prio;
  logic              r_id;
  logic [31:0]       r_data;
  logic              r_flag;
  logic              r_err;
  logic [31:0]       r_shift;
  logic [5:0]        r_acc;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_gnt;
  logic [2:0]        w_op;
  logic [31:0]       w_a;
  logic [31:0]       w_b;
  logic [15:0]       w_imm;
  logic [31:0]       w_res;
  logic              w_flag;
  logic              w_err;
  logic              w_accept;
  logic              w_ham_done;
  logic [5:0]        w_acc_nxt;

  function automatic logic [PC_W-1:0] popcnt(input logic [HAM_BITS-1:0] v);
    logic [PC_W-1:0] c;
    c = '0;
    for (int unsigned i = 0; i < HAM_BITS; i++) c = c + PC_W'(v[i]);
    return c;
  endfunction

  // Pointer only matters when both request; otherwise the lone valid wins.
  assign w_gnt = (&req_valid) ? r_prio : req_valid[1];
  assign w_op  = w_gnt ? req_op[5:3]    : req_op[2:0];
  assign w_a   = w_gnt ? req_a[63:32]   : req_a[31:0];
  assign w_b   = w_gnt ? req_b[63:32]   : req_b[31:0];
  assign w_imm = w_gnt ? req_imm[31:16] : req_imm[15:0];

  assign w_acc_nxt = r_acc + 6'(popcnt(r_shift[HAM_BITS-1:0]));

  always_comb begin
    w_res  = '0;
    w_flag = 1'b0;
    w_err  = 1'b0;
    case (w_op)
      OP_INC: {w_flag, w_res} = {1'b0, w_a} + 33'd1;
      OP_DEC: {w_flag, w_res} = {1'b0, w_a} - 33'd1;
      OP_SLT: w_res = 32'($signed(w_a) < $signed(w_b));
      OP_SGT: w_res = 32'($signed(w_a) > $signed(w_b));
      OP_LUI: w_res = {w_imm, 16'h0000};
      OP_HAM: w_res = '0;
      default: w_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = (w_op == OP_HAM) ? S_HAM : S_RESP;
      S_HAM:  if (w_ham_done) w_state_nxt = S_RESP;
      S_RESP: if (rsp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = 2'b00;
    w_accept   = 1'b0;
    w_ham_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!rst && (|req_valid)) begin
          req_ready[w_gnt] = 1'b1;
          w_accept         = 1'b1;
        end
      end
      S_HAM:   w_ham_done = (r_cnt == CNT_W'(HAM_CYC - 1));
      default: ;
    endcase
  end

  // Result/response registers and the bit-serial Hamming datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prio  <= 1'b0;
      r_id    <= 1'b0;
      r_data  <= '0;
      r_flag  <= 1'b0;
      r_err   <= 1'b0;
      r_shift <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_id   <= w_gnt;
      r_prio <= ~w_gnt;
      if (w_op == OP_HAM) begin
        r_shift <= w_a;
        r_acc   <= '0;
        r_cnt   <= '0;
        r_flag  <= 1'b0;
        r_err   <= 1'b0;
      end else begin
        r_data <= w_res;
        r_flag <= w_flag;
        r_err  <= w_err;
      end
    end else if (r_state == S_HAM) begin
      r_shift <= r_shift >> HAM_BITS;
      r_acc   <= w_acc_nxt;
      r_cnt   <= r_cnt + CNT_W'(1);
      if (w_ham_done) r_data <= 32'(w_acc_nxt);
    end
  end

  assign rsp_valid = (r_state == S_RESP);
  assign busy      = (r_state != S_IDLE);
  assign rsp_id    = r_id;
  assign rsp_data  = r_data;
  assign rsp_flag  = r_flag;
  assign rsp_err   = r_err;

endmodule

// File: tb/tb_ext_op_sched.sv
// Directed bench for ext_op_sched: vector table of single ops plus
// hand-written arbitration, backpressure and reset-abort sequences.
module tb_ext_op_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [5:0]  req_op;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [31:0] req_imm;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_data;
  logic        rsp_flag;
  logic        rsp_err;
  logic        busy;

  int n_checks = 0;
  int n_err    = 0;

  ext_op_sched #(.HAM_BITS(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_imm(req_imm),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_flag(rsp_flag), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        id;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [15:0] imm;
    logic [31:0] data;
    logic        flag;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive_slot(input logic id, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [15:0] imm);
    if (id) begin
      req_op[5:3] = op; req_a[63:32] = a; req_b[63:32] = b; req_imm[31:16] = imm;
    end else begin
      req_op[2:0] = op; req_a[31:0] = a; req_b[31:0] = b; req_imm[15:0] = imm;
    end
  endtask

  task automatic do_op(input vec_t v, input int idx);
    int lat;
    bit got;
    logic [1:0] exp_rdy;
    exp_rdy = v.id ? 2'b10 : 2'b01;
    @(negedge clk);
    drive_slot(v.id, v.op, v.a, v.b, v.imm);
    req_valid = exp_rdy;
    #1;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      if (req_ready == exp_rdy) got = 1'b1;
      else begin @(negedge clk); #1; end
    end
    chk($sformatf("v%0d grant", idx), 32'(req_ready), 32'(exp_rdy));
    if (!got) begin
      req_valid = 2'b00;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    // Scramble payload after accept; the op in flight must not change.
    req_valid = 2'b00;
    req_op = 6'($urandom); req_a = {$urandom, $urandom}; req_b = {$urandom, $urandom};
    req_imm = $urandom;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk($sformatf("v%0d latency", idx), 32'(lat), 32'(v.lat));
    chk($sformatf("v%0d id", idx), 32'(rsp_id), 32'(v.id));
    chk($sformatf("v%0d data", idx), rsp_data, v.data);
    chk($sformatf("v%0d flag", idx), 32'(rsp_flag), 32'(v.flag));
    chk($sformatf("v%0d err", idx), 32'(rsp_err), 32'(v.err));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk($sformatf("v%0d idle_after_hs", idx), 32'({rsp_valid, busy}), 32'(0));
  endtask

  initial begin
    bit seen;
    vecs[0]  = '{1'b0, 3'd0, 32'hFFFFFFFF, 32'h0,        16'h0,    32'h00000000, 1'b1, 1'b0, 1};
    vecs[1]  = '{1'b1, 3'd0, 32'h12345678, 32'h0,        16'h0,    32'h12345679, 1'b0, 1'b0, 1};
    vecs[2]  = '{1'b0, 3'd1, 32'h00000000, 32'h0,        16'h0,    32'hFFFFFFFF, 1'b1, 1'b0, 1};
    vecs[3]  = '{1'b1, 3'd1, 32'h80000000, 32'h0,        16'h0,    32'h7FFFFFFF, 1'b0, 1'b0, 1};
    vecs[4]  = '{1'b0, 3'd2, 32'hFFFFFFFF, 32'h1,        16'h0,    32'h00000001, 1'b0, 1'b0, 1};
    vecs[5]  = '{1'b1, 3'd2, 32'h00000005, 32'h5,        16'h0,    32'h00000000, 1'b0, 1'b0, 1};
    vecs[6]  = '{1'b0, 3'd2, 32'h00000001, 32'h80000000, 16'h0,    32'h00000000, 1'b0, 1'b0, 1};
    vecs[7]  = '{1'b0, 3'd3, 32'h7FFFFFFF, 32'h80000000, 16'h0,    32'h00000001, 1'b0, 1'b0, 1};
    vecs[8]  = '{1'b1, 3'd3, 32'h00000064, 32'h64,       16'h0,    32'h00000000, 1'b0, 1'b0, 1};
    vecs[9]  = '{1'b1, 3'd3, 32'hFFFFFFFE, 32'hFFFFFFFF, 16'h0,    32'h00000000, 1'b0, 1'b0, 1};
    vecs[10] = '{1'b0, 3'd4, 32'h0,        32'h0,        16'h1234, 32'h12340000, 1'b0, 1'b0, 1};
    vecs[11] = '{1'b1, 3'd5, 32'hAAAAAAAA, 32'h0,        16'h0,    32'h00000010, 1'b0, 1'b0, 9};
    vecs[12] = '{1'b1, 3'd5, 32'hFFFFFFFF, 32'h0,        16'h0,    32'h00000020, 1'b0, 1'b0, 9};
    vecs[13] = '{1'b0, 3'd5, 32'h00000000, 32'h0,        16'h0,    32'h00000000, 1'b0, 1'b0, 9};
    vecs[14] = '{1'b0, 3'd5, 32'h12345678, 32'h0,        16'h0,    32'h0000000D, 1'b0, 1'b0, 9};
    vecs[15] = '{1'b1, 3'd7, 32'hFFFFFFFF, 32'h0,        16'hFFFF, 32'h00000000, 1'b0, 1'b1, 1};
    vecs[16] = '{1'b0, 3'd6, 32'hFFFFFFFF, 32'h0,        16'hFFFF, 32'h00000000, 1'b0, 1'b1, 1};

    // Reset state, with both requesters asserting valid during reset.
    rst = 1'b1; rsp_ready = 1'b0; req_valid = 2'b11;
    req_op = '0; req_a = '0; req_b = '0; req_imm = '0;
    repeat (2) @(negedge clk);
    chk("rst outputs", 32'({rsp_valid, rsp_id, rsp_flag, rsp_err, busy}), 32'(0));
    chk("rst data", rsp_data, 32'h0);
    chk("rst req_ready", 32'(req_ready), 32'(0));
    rst = 1'b0; req_valid = 2'b00;

    // Both valid: req0 first, then req1 exactly one round later; req0 re-requests meanwhile.
    @(negedge clk);
    drive_slot(1'b0, 3'd1, 32'h0, 32'h0, 16'h0);
    drive_slot(1'b1, 3'd2, 32'hFFFFFFFF, 32'h1, 16'h0);
    req_valid = 2'b11; rsp_ready = 1'b1;
    #1 chk("rr first grant", 32'(req_ready), 32'(2'b01));
    @(negedge clk);
    drive_slot(1'b0, 3'd0, 32'h5, 32'h0, 16'h0);
    chk("rr rsp0 valid", 32'(rsp_valid), 32'(1));
    chk("rr rsp0 id", 32'(rsp_id), 32'(0));
    chk("rr rsp0 data", rsp_data, 32'hFFFFFFFF);
    chk("rr rsp0 flag", 32'(rsp_flag), 32'(1));
    chk("rr ready in resp", 32'(req_ready), 32'(0));
    @(negedge clk);
    #1;
    chk("rr hs drops valid", 32'(rsp_valid), 32'(0));
    chk("rr second grant", 32'(req_ready), 32'(2'b10));
    @(negedge clk);
    req_valid = 2'b01;
    chk("rr rsp1 id", 32'(rsp_id), 32'(1));
    chk("rr rsp1 data", rsp_data, 32'h00000001);
    chk("rr rsp1 flag", 32'(rsp_flag), 32'(0));
    @(negedge clk);
    #1;
    chk("rr third grant", 32'(req_ready), 32'(2'b01));
    req_valid = 2'b00; rsp_ready = 1'b0;

    for (int i = 0; i < 17; i++) do_op(vecs[i], i);

    // Backpressure: LUI held 5 cycles while req1 waits unserved.
    @(negedge clk);
    drive_slot(1'b0, 3'd4, 32'h0, 32'h0, 16'hBEEF);
    req_valid = 2'b01;
    #1 chk("bp grant", 32'(req_ready), 32'(2'b01));
    @(negedge clk);
    drive_slot(1'b1, 3'd0, 32'h1, 32'h0, 16'h0);
    req_valid = 2'b10;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("bp valid c%0d", i), 32'(rsp_valid), 32'(1));
      chk($sformatf("bp data c%0d", i), rsp_data, 32'hBEEF0000);
      chk($sformatf("bp ready c%0d", i), 32'(req_ready), 32'(0));
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("bp idle after hs", 32'({rsp_valid, busy}), 32'(0));
    chk("bp req1 now granted", 32'(req_ready), 32'(2'b10));
    req_valid = 2'b00; rsp_ready = 1'b0;

    // Reset during the 3rd HAM cycle abandons the op.
    @(negedge clk);
    drive_slot(1'b1, 3'd5, 32'hFFFFFFFF, 32'h0, 16'h0);
    req_valid = 2'b10;
    #1 chk("abort grant", 32'(req_ready), 32'(2'b10));
    @(negedge clk);
    req_valid = 2'b00;
    chk("abort busy", 32'({busy, rsp_valid}), 32'(2'b10));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    drive_slot(1'b0, 3'd0, 32'h0, 32'h0, 16'h0);
    drive_slot(1'b1, 3'd0, 32'h0, 32'h0, 16'h0);
    req_valid = 2'b11;
    @(negedge clk);
    chk("abort outputs", 32'({rsp_valid, rsp_id, rsp_flag, rsp_err, busy}), 32'(0));
    chk("abort data", rsp_data, 32'h0);
    chk("abort ready in rst", 32'(req_ready), 32'(0));
    rst = 1'b0;
    #1 chk("abort req0 first", 32'(req_ready), 32'(2'b01));
    req_valid = 2'b00;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    chk("abort no response", 32'(seen), 32'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
